// File: rtl/load_store_unit.sv
// Sequential load/store unit for a 64-byte word-oriented data memory.
// Sub-word stores are done as read-modify-write of the containing word.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        RespValid,
  output logic [31:0] LoadData,
  output logic        Fault,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemReadData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_RMW_WR,
    S_STORE,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] buf_q, buf_d;
  logic        fault_q, fault_d;

  logic        req_fault;
  logic [31:0] merged;
  logic [31:0] ext;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    req_fault = 1'b0;
    if (Funct3 == 3'b011 || Funct3 == 3'b110 || Funct3 == 3'b111)
      req_fault = 1'b1;
    if (ReqWrite && Funct3[2])
      req_fault = 1'b1;
    if (Funct3[1:0] == 2'b01 && Addr[0])
      req_fault = 1'b1;
    if (Funct3 == 3'b010 && Addr[1:0] != 2'b00)
      req_fault = 1'b1;
    if (Addr > 32'(MEM_BYTES - 1))
      req_fault = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    buf_d    = buf_q;
    fault_d  = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (ReqValid) begin
          write_d  = ReqWrite;
          funct3_d = Funct3;
          addr_d   = Addr;
          sdata_d  = StoreData;
          fault_d  = req_fault;
          if (req_fault)
            state_d = S_RESP;
          else if (!ReqWrite)
            state_d = S_LOAD;
          else if (Funct3 == 3'b010)
            state_d = S_STORE;
          else
            state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        buf_d   = MemReadData;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        buf_d   = MemReadData;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_RESP;
      S_STORE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      sdata_q  <= 32'h0;
      buf_q    <= 32'h0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      buf_q    <= buf_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    merged = buf_q;
    if (funct3_q[1:0] == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = sdata_q[15:0];
  end

  // Rst gates the strobes so an aborted store never reaches memory
  always_comb begin
    MemRead      = !Rst && (state_q == S_LOAD || state_q == S_RMW_RD);
    MemWrite     = !Rst && (state_q == S_STORE || state_q == S_RMW_WR);
    MemAddress   = 32'h0;
    MemWriteData = 32'h0;
    if (MemRead || MemWrite)
      MemAddress = {addr_q[31:2], 2'b00};
    if (MemWrite)
      MemWriteData = (state_q == S_STORE) ? sdata_q : merged;
  end

  always_comb begin
    sel_b = buf_q[{addr_q[1:0], 3'b000} +: 8];
    sel_h = buf_q[{addr_q[1], 4'b0000} +: 16];
    ext   = 32'h0;
    unique case (funct3_q)
      3'b000:  ext = {{24{sel_b[7]}}, sel_b};
      3'b001:  ext = {{16{sel_h[15]}}, sel_h};
      3'b010:  ext = buf_q;
      3'b100:  ext = {24'h0, sel_b};
      3'b101:  ext = {16'h0, sel_h};
      default: ext = 32'h0;
    endcase
  end

  assign ReqReady  = (state_q == S_IDLE);
  assign RespValid = (state_q == S_RESP);
  assign Fault     = RespValid && fault_q;
  assign LoadData  = (RespValid && !write_q && !fault_q) ? ext : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference model, directed
// scenarios and randomized traffic against a word-wide memory model.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        RespValid;
  logic [31:0] LoadData;
  logic        Fault;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemReadData;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_w [16];
  logic [7:0]  ref_mem [64];

  int          r_lat, r_rdc, r_wrc;
  logic [31:0] r_ld, r_ma, r_wd;
  logic        r_flt;

  load_store_unit #(.MEM_BYTES(64)) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .Funct3(Funct3),
    .Addr(Addr), .StoreData(StoreData),
    .RespValid(RespValid), .LoadData(LoadData),
    .Fault(Fault), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  always #5 Clk = ~Clk;

  assign MemReadData = mem_w[MemAddress[5:2]];

  always @(posedge Clk)
    if (MemWrite) mem_w[MemAddress[5:2]] <= MemWriteData;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic exp_fault(input logic w, input logic [2:0] f3,
                                     input logic [31:0] a);
    int nb;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (w && f3 >= 3'd4) return 1'b1;
    if (a >= 64) return 1'b1;
    nb = (f3 == 3'd2) ? 4 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 1;
    return (a % nb) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3,
                                           input logic [31:0] a);
    int i;
    int v;
    i = int'(a[5:0]);
    case (f3)
      3'd0: begin v = int'(ref_mem[i]); if (v >= 128) v -= 256; end
      3'd4: v = int'(ref_mem[i]);
      3'd1: begin
        v = int'(ref_mem[i]) + 256 * int'(ref_mem[i+1]);
        if (v >= 32768) v -= 65536;
      end
      3'd5: v = int'(ref_mem[i]) + 256 * int'(ref_mem[i+1]);
      default: return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    endcase
    return 32'(v);
  endfunction

  function automatic int exp_lat(input logic w, input logic [2:0] f3,
                                 input logic [31:0] a);
    if (exp_fault(w, f3, a)) return 1;
    if (!w || f3 == 3'd2) return 2;
    return 3;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
    int nb;
    nb = (f3 == 3'd2) ? 4 : (f3 == 3'd1) ? 2 : 1;
    for (int k = 0; k < nb; k++)
      ref_mem[int'(a[5:0]) + k] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int i;
    i = int'(a[5:0]) & ~3;
    return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
  endfunction

  task automatic do_req(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
    int n;
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = w; Funct3 = f3;
    Addr = a; StoreData = sd;
    n = 0;
    while (!ReqReady && n < 20) begin @(negedge Clk); n++; end
    @(posedge Clk);
    #1;
    ReqValid = 1'b0; ReqWrite = $urandom; Funct3 = 3'($urandom);
    Addr = $urandom; StoreData = $urandom;
    r_lat = 0; r_rdc = 0; r_wrc = 0;
    r_ld = 32'h0; r_ma = 32'h0; r_wd = 32'h0; r_flt = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk);
      if (MemRead) begin r_rdc = i; r_ma = MemAddress; end
      if (MemWrite) begin r_wrc = i; r_ma = MemAddress; r_wd = MemWriteData; end
      if (RespValid) begin
        r_lat = i; r_ld = LoadData; r_flt = Fault;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0;
    Funct3 = 3'd0; Addr = 32'h0; StoreData = 32'h0;
    repeat (3) @(negedge Clk);
    checks++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0 || Fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b resp=%b fault=%b want 1 0 0",
               ReqReady, RespValid, Fault);
    end
    checks++;
    if (MemRead !== 1'b0 || MemWrite !== 1'b0 || MemAddress !== 32'h0 ||
        MemWriteData !== 32'h0 || LoadData !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: rd=%b wr=%b addr=%h wd=%h ld=%h want zeros",
               MemRead, MemWrite, MemAddress, MemWriteData, LoadData);
    end
    Rst = 1'b0;
  endtask

  task automatic test_init_mem;
    logic [31:0] d;
    for (int wi = 0; wi < 16; wi++) begin
      d = $urandom;
      do_req(1'b1, 3'd2, 32'(4 * wi), d);
      ref_store(3'd2, 32'(4 * wi), d);
      checks++;
      if (r_lat !== 2 || r_flt !== 1'b0 || r_wd !== d) begin
        errors++;
        $display("FAIL init_sw: lat=%0d fault=%b wd=%h want 2 0 %h",
                 r_lat, r_flt, r_wd, d);
      end
    end
  endtask

  task automatic test_load;
    logic [2:0]  f3s [4];
    logic [31:0] as  [4];
    logic [31:0] ws  [4];
    do_req(1'b1, 3'd2, 32'h08, 32'h11223344);
    ref_store(3'd2, 32'h08, 32'h11223344);
    do_req(1'b0, 3'd2, 32'h08, 32'h0);
    checks++;
    if (r_lat !== 2 || r_ld !== 32'h11223344 || r_flt !== 1'b0 ||
        r_rdc !== 1 || r_ma !== 32'h08) begin
      errors++;
      $display("FAIL lw_basic: lat=%0d ld=%h flt=%b rdc=%0d ma=%h",
               r_lat, r_ld, r_flt, r_rdc, r_ma);
    end
    do_req(1'b1, 3'd2, 32'h08, 32'h80228344);
    ref_store(3'd2, 32'h08, 32'h80228344);
    f3s[0] = 3'd0; as[0] = 32'h09; ws[0] = 32'hFFFFFF83;
    f3s[1] = 3'd4; as[1] = 32'h09; ws[1] = 32'h00000083;
    f3s[2] = 3'd1; as[2] = 32'h0A; ws[2] = 32'hFFFF8022;
    f3s[3] = 3'd5; as[3] = 32'h0A; ws[3] = 32'h00008022;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3s[i], as[i], 32'h0);
      checks++;
      if (r_ld !== ws[i] || r_ld !== exp_load(f3s[i], as[i]) ||
          r_lat !== 2 || r_flt !== 1'b0) begin
        errors++;
        $display("FAIL subword_load f3=%0d a=%h: ld=%h lat=%0d want %h",
                 f3s[i], as[i], r_ld, r_lat, ws[i]);
      end
    end
  endtask

  task automatic test_sb;
    do_req(1'b1, 3'd2, 32'h0C, 32'h11223344);
    ref_store(3'd2, 32'h0C, 32'h11223344);
    do_req(1'b1, 3'd0, 32'h0D, 32'hAABBCCEE);
    ref_store(3'd0, 32'h0D, 32'hAABBCCEE);
    checks++;
    if (r_rdc !== 1 || r_wrc !== 2 || r_lat !== 3 ||
        r_wd !== 32'h1122EE44 || r_wd !== ref_word(32'h0C) ||
        r_ld !== 32'h0) begin
      errors++;
      $display("FAIL sb_rmw: rdc=%0d wrc=%0d lat=%0d wd=%h ld=%h",
               r_rdc, r_wrc, r_lat, r_wd, r_ld);
    end
    do_req(1'b0, 3'd2, 32'h0C, 32'h0);
    checks++;
    if (r_ld !== 32'h1122EE44) begin
      errors++;
      $display("FAIL sb_readback: ld=%h want 1122ee44", r_ld);
    end
  endtask

  task automatic test_faults;
    logic        ws  [4];
    logic [2:0]  f3s [4];
    logic [31:0] as  [4];
    ws[0] = 1'b0; f3s[0] = 3'd2; as[0] = 32'h06;
    ws[1] = 1'b0; f3s[1] = 3'd1; as[1] = 32'h03;
    ws[2] = 1'b1; f3s[2] = 3'd4; as[2] = 32'h04;
    ws[3] = 1'b0; f3s[3] = 3'd2; as[3] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      do_req(ws[i], f3s[i], as[i], 32'hDEADBEEF);
      checks++;
      if (r_lat !== 1 || r_flt !== 1'b1 || r_ld !== 32'h0 ||
          r_rdc !== 0 || r_wrc !== 0) begin
        errors++;
        $display("FAIL fault_%0d: lat=%0d flt=%b ld=%h rdc=%0d wrc=%0d",
                 i, r_lat, r_flt, r_ld, r_rdc, r_wrc);
      end
    end
  endtask

  task automatic test_reset_abort;
    int n;
    logic seen;
    do_req(1'b1, 3'd2, 32'h10, 32'h55667788);
    ref_store(3'd2, 32'h10, 32'h55667788);
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b1; Funct3 = 3'd1;
    Addr = 32'h12; StoreData = 32'h0000ABCD;
    @(posedge Clk);
    #1 ReqValid = 1'b0;
    n = 0;
    do begin @(negedge Clk); n++; end while (!MemWrite && n < 5);
    checks++;
    if (MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach_wr: memwrite=%b want 1", MemWrite);
    end
    #2 Rst = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || RespValid !== 1'b0 || ReqReady !== 1'b1) begin
      errors++;
      $display("FAIL abort_rst: wr=%b resp=%b ready=%b want 0 0 1",
               MemWrite, RespValid, ReqReady);
    end
    @(negedge Clk);
    Rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge Clk); if (RespValid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_noresp: respvalid seen=%b want 0", seen);
    end
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    checks++;
    if (r_ld !== ref_word(32'h10)) begin
      errors++;
      $display("FAIL abort_mem: ld=%h want %h", r_ld, ref_word(32'h10));
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    int resp_cyc, acc_cyc, lat2;
    logic [31:0] ld2;
    d = $urandom;
    resp_cyc = 0; acc_cyc = 0; lat2 = 0; ld2 = 32'h0;
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b1; Funct3 = 3'd2;
    Addr = 32'h20; StoreData = d;
    @(posedge Clk);
    #1 ReqWrite = 1'b0; StoreData = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (RespValid && resp_cyc == 0) resp_cyc = c;
      if (ReqReady) begin
        acc_cyc = c;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        break;
      end
    end
    ref_store(3'd2, 32'h20, d);
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (RespValid) begin lat2 = c; ld2 = LoadData; break; end
    end
    checks++;
    if (resp_cyc !== 2 || acc_cyc !== 3) begin
      errors++;
      $display("FAIL b2b_accept: resp_cyc=%0d acc_cyc=%0d want 2 3",
               resp_cyc, acc_cyc);
    end
    checks++;
    if (lat2 !== 2 || ld2 !== exp_load(3'd2, 32'h20)) begin
      errors++;
      $display("FAIL b2b_load: lat=%0d ld=%h want 2 %h", lat2, ld2, d);
    end
  endtask

  task automatic test_random;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a, d, el;
    logic        ef;
    int          el_lat;
    for (int t = 0; t < 80; t++) begin
      w  = $urandom;
      f3 = 3'($urandom);
      d  = $urandom;
      case ($urandom_range(0, 9))
        0: a = $urandom_range(64, 300);
        1: a = 32'hFFFF_FFFC;
        default: a = $urandom_range(0, 63);
      endcase
      ef = exp_fault(w, f3, a);
      el_lat = exp_lat(w, f3, a);
      el = (ef || w) ? 32'h0 : exp_load(f3, a);
      do_req(w, f3, a, d);
      if (!ef && w) ref_store(f3, a, d);
      checks++;
      if (r_lat !== el_lat || r_flt !== ef || r_ld !== el) begin
        errors++;
        $display("FAIL rand_%0d w=%b f3=%0d a=%h: lat=%0d flt=%b ld=%h want %0d %b %h",
                 t, w, f3, a, r_lat, r_flt, r_ld, el_lat, ef, el);
      end
      if (ef || !w) begin
        checks++;
        if (r_wrc !== 0 || (ef && r_rdc !== 0)) begin
          errors++;
          $display("FAIL rand_access_%0d: rdc=%0d wrc=%0d want no access",
                   t, r_rdc, r_wrc);
        end
      end else begin
        checks++;
        if (r_wd !== ref_word(a) || r_ma !== {a[31:2], 2'b00}) begin
          errors++;
          $display("FAIL rand_store_%0d: wd=%h ma=%h want %h %h",
                   t, r_wd, r_ma, ref_word(a), {a[31:2], 2'b00});
        end
      end
    end
    for (int wi = 0; wi < 16; wi++) begin
      do_req(1'b0, 3'd2, 32'(4 * wi), 32'h0);
      checks++;
      if (r_ld !== ref_word(32'(4 * wi))) begin
        errors++;
        $display("FAIL final_word_%0d: ld=%h want %h",
                 wi, r_ld, ref_word(32'(4 * wi)));
      end
    end
  endtask

  initial begin
    test_reset;
    test_init_mem;
    test_load;
    test_sb;
    test_faults;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
